pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL provide parameter GROUP = 4 (fixed), lookahead group size in bits; number of groups NG = WIDTH/4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in; ignored when op_sub=1.
REQ-010 op_sub  input  1  0 = A+B+ci, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Effective operand SHALL be b_eff = op_sub ? ~b : b, and c_in_eff = op_sub ? 1 : ci.
REQ-017 Stage 1 SHALL register per-bit p = a ^ b_eff, g = a & b_eff, per-group P (AND of 4 p) and G (g3 | p3g2 | p3p2g1 | p3p2p1g0), c_in_eff, and the sign bits a[MSB], b_eff[MSB].
REQ-018 Stage 2 SHALL compute group carries by two-level lookahead: C[k+1] = G[k] | (P[k] & C[k]), C[0] = c_in_eff, computed combinationally without ripple across individual bits, then intra-group carries c[i+1] = g[i] | (p[i] & c[i]) within each group, and register sum = p ^ c, cout = C[NG], ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
REQ-019 Latency SHALL be exactly 2 cycles from accepted input beat to out_valid with no stall; sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-020 A beat is accepted when in_valid & in_ready; a result is consumed when out_valid & out_ready.
REQ-021 Stage 2 SHALL load when (!s2_valid | out_ready); stage 1 SHALL advance into stage 2 under the same condition.
REQ-022 in_ready SHALL equal !s1_valid | (!s2_valid | out_ready); the combinational path out_ready -> in_ready is permitted.
REQ-023 While out_valid=1 and out_ready=0, sum/cout/ovf SHALL hold stable and out_valid SHALL remain 1.
REQ-024 With both stages full and out_ready=0, in_ready SHALL be 0; no beat SHALL be dropped, duplicated or reordered.
REQ-025 Simultaneous consume at stage 2 and accept at stage 1 in one cycle SHALL retain full throughput (no bubble inserted).
REQ-026 Stage valid flags SHALL clear when a stage empties without refill; data registers need not clear.
REQ-027 All arithmetic SHALL be modulo 2^WIDTH; carry beyond MSB appears only on cout.

Reset
REQ-028 On rst=1 at a clock edge: s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts; rst=1 SHALL dominate in_valid in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear after it.

Verification
REQ-031 WIDTH=16, a=0xFFFF, b=0x0001, ci=0, op_sub=0 -> two cycles later sum=0x0000, cout=1, ovf=0.
REQ-032 WIDTH=16, a=0x7FFF, b=0x0001, ci=0 -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, op_sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-033 Backpressure: out_ready=0, offer 3 consecutive beats -> exactly 2 accepted, in_ready=0 from third cycle, outputs held; release out_ready -> results emerge in order, one per cycle.
REQ-034 Streaming: 100 random beats with in_valid=1, out_ready=1 -> 1 result/cycle after 2-cycle fill, each matches reference model a+b+ci or a-b.
REQ-035 Reset mid-stream with both stages full -> out_valid=0 next cycle, sum=0, no stale result emitted after rst deasserts.
REQ-036 Parameter sweep WIDTH=4, 32, 64: carry-chain corner a=all-ones, b=0, ci=1 -> sum=0, cout=1.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready
// handshake on both sides.
//
//   Stage 1 registers the per-bit propagate/generate terms, the per-group
//   (4-bit) propagate/generate terms, the effective carry-in and the two
//   operand sign bits.
//   Stage 2 resolves group carries with a flattened lookahead (sum of
//   products, no ripple through individual bits), derives the intra-group
//   bit carries, and registers sum, cout and signed overflow.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle when in_valid is also high
//   a, b       operands, WIDTH bits
//   ci         carry-in (ignored when op_sub = 1)
//   op_sub     0: a + b + ci, 1: a - b
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result bits, modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 means no borrow)
//   ovf        two's-complement signed overflow
//
// Parameters
//   WIDTH      operand width, multiple of 4 from 4 to 64
//   GROUP      lookahead group size (4)
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    // Per-group propagate: every bit of the group propagates.
    function automatic logic [NG-1:0] group_prop(input logic [WIDTH-1:0] p);
        logic [NG-1:0] gp;
        gp = '0;
        for (int k = 0; k < NG; k++) begin
            gp[k] = &p[k*GROUP +: GROUP];
        end
        return gp;
    endfunction

    // Per-group generate as a flat sum of products:
    // g3 | p3g2 | p3p2g1 | p3p2p1g0 for a 4-bit group.
    function automatic logic [NG-1:0] group_gen(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] g);
        logic [NG-1:0] gg;
        logic          term;
        gg = '0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                term = g[k*GROUP + i];
                for (int j = i + 1; j < GROUP; j++) begin
                    term = term & p[k*GROUP + j];
                end
                gg[k] = gg[k] | term;
            end
        end
        return gg;
    endfunction

    // Group carries C[0..NG]. Each C[k+1] is expanded into its full
    // product terms so no carry depends on a previously computed carry:
    // C[k+1] = G[k] | P[k]G[k-1] | ... | P[k]..P[0]C[0].
    function automatic logic [NG:0] group_carries(input logic [NG-1:0] gp,
                                                  input logic [NG-1:0] gg,
                                                  input logic          c0);
        logic [NG:0] gc;
        logic        term;
        gc    = '0;
        gc[0] = c0;
        for (int k = 0; k < NG; k++) begin
            term = c0;
            for (int j = 0; j <= k; j++) begin
                term = term & gp[j];
            end
            gc[k+1] = term;
            for (int j = 0; j <= k; j++) begin
                term = gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & gp[m];
                end
                gc[k+1] = gc[k+1] | term;
            end
        end
        return gc;
    endfunction

    // Bit carries inside each group, seeded by that group's carry-in.
    // The chain is only GROUP bits long, never across group boundaries.
    function automatic logic [WIDTH-1:0] bit_carries(input logic [WIDTH-1:0] p,
                                                     input logic [WIDTH-1:0] g,
                                                     input logic [NG:0]      gc);
        logic [WIDTH-1:0] c;
        logic             cc;
        c = '0;
        for (int k = 0; k < NG; k++) begin
            cc = gc[k];
            for (int i = 0; i < GROUP; i++) begin
                c[k*GROUP + i] = cc;
                cc = g[k*GROUP + i] | (p[k*GROUP + i] & cc);
            end
        end
        return c;
    endfunction

    // Signed overflow: operands agree in sign, result sign differs.
    function automatic logic signed_overflow(input logic sign_a,
                                             input logic sign_b,
                                             input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

    // Handshake
    logic adv;
    logic vld_p1;
    logic vld_p2;

    assign adv      = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv;

    // ---------------- stage 0: operand conditioning (combinational) -------
    logic [WIDTH-1:0] b_eff_p0;
    logic             cin_p0;
    logic [WIDTH-1:0] p_p0;
    logic [WIDTH-1:0] g_p0;

    assign b_eff_p0 = op_sub ? ~b : b;
    assign cin_p0   = op_sub ? 1'b1 : ci;
    assign p_p0     = a ^ b_eff_p0;
    assign g_p0     = a & b_eff_p0;

    // ---------------- stage 1: propagate/generate registers ---------------
    logic [WIDTH-1:0] p_p1;
    logic [WIDTH-1:0] g_p1;
    logic [NG-1:0]    gp_p1;
    logic [NG-1:0]    gg_p1;
    logic             cin_p1;
    logic             sa_p1;
    logic             sb_p1;

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            p_p1   <= p_p0;
            g_p1   <= g_p0;
            gp_p1  <= group_prop(p_p0);
            gg_p1  <= group_gen(p_p0, g_p0);
            cin_p1 <= cin_p0;
            sa_p1  <= a[WIDTH-1];
            sb_p1  <= b_eff_p0[WIDTH-1];
        end
    end

    // ---------------- stage 2: carry resolution and result ----------------
    logic [NG:0]      gc_p1;
    logic [WIDTH-1:0] c_p1;
    logic [WIDTH-1:0] s_p1;

    assign gc_p1 = group_carries(gp_p1, gg_p1, cin_p1);
    assign c_p1  = bit_carries(p_p1, g_p1, gc_p1);
    assign s_p1  = p_p1 ^ c_p1;

    logic [WIDTH-1:0] sum_p2;
    logic             cout_p2;
    logic             ovf_p2;

    // Result registers clear on reset so the outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
        end else if (adv && vld_p1) begin
            sum_p2  <= s_p1;
            cout_p2 <= gc_p1[NG];
            ovf_p2  <= signed_overflow(sa_p1, sb_p1, s_p1[WIDTH-1]);
        end
    end

    // Valid flags: stage 1 refills whenever it can accept; stage 2 takes
    // whatever stage 1 holds (possibly a bubble) whenever it may advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (adv) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign sum       = sum_p2;
    assign cout      = cout_p2;
    assign ovf       = ovf_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Bench for pipelined_cla_adder (WIDTH=16 main instance plus WIDTH=4/32/64
// instances for the all-ones carry-chain corner). Expected results are pushed
// to a queue when a beat is accepted and compared when the result is consumed.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    pipelined_cla_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Width-sweep instances: a = all ones, b = 0, ci = 1, add.
    logic        sw_valid;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        rdy4, rdy32, rdy64;
    logic        ov4, ov32, ov64;
    logic [3:0]  s4;
    logic [31:0] s32;
    logic [63:0] s64;
    logic        co4, co32, co64;
    logic        of4, of32, of64;

    pipelined_cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy4),
        .a(a4), .b(b4), .ci(1'b1), .op_sub(1'b0),
        .out_valid(ov4), .out_ready(1'b1), .sum(s4), .cout(co4), .ovf(of4)
    );
    pipelined_cla_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy32),
        .a(a32), .b(b32), .ci(1'b1), .op_sub(1'b0),
        .out_valid(ov32), .out_ready(1'b1), .sum(s32), .cout(co32), .ovf(of32)
    );
    pipelined_cla_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy64),
        .a(a64), .b(b64), .ci(1'b1), .op_sub(1'b0),
        .out_valid(ov64), .out_ready(1'b1), .sum(s64), .cout(co64), .ovf(of64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string nm, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", nm, msg);
        end
    endtask

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    exp_t        q[$];
    int          cyc = 0;
    bit          chk_lat = 1'b0;
    logic [15:0] cur_s;
    logic        cur_c;
    logic        cur_o;

    // Reference: unsigned and signed integer arithmetic.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mci, input logic msub,
                                  output logic [15:0] ms, output logic mc,
                                  output logic mo);
        int ua, ub, sa, sb, full, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            full = ua + ub + int'(mci);
            sr   = sa + sb + int'(mci);
            mc   = (full > 65535);
        end else begin
            full = ua - ub;
            sr   = sa - sb;
            mc   = (ua >= ub);
        end
        ms = 16'(full);
        mo = (sr > 32767) || (sr < -32768);
    endfunction

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk(q.size() != 0, "stale_out",
                    $sformatf("result sum=%h with nothing expected", sum));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk(sum == e.s && cout == e.c && ovf == e.o, "result",
                        $sformatf("got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                  sum, cout, ovf, e.s, e.c, e.o));
                    if (chk_lat)
                        chk(cyc - e.cyc == 2, "latency",
                            $sformatf("got %0d cycles, want 2", cyc - e.cyc));
                end
            end
            if (chk_lat && in_valid)
                chk(in_ready == 1'b1, "throughput",
                    $sformatf("in_ready=%b, want 1", in_ready));
            if (in_valid && in_ready) begin
                e.s = cur_s; e.c = cur_c; e.o = cur_o; e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tci, input logic tsub,
                        input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(posedge clk); #1;
        a = ta; b = tb; ci = tci; op_sub = tsub;
        cur_s = es; cur_c = ec; cur_o = eo;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk(1'b0, "accept_timeout", "in_ready stayed 0, want 1");
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    vec_t vt[12];

    initial begin
        logic [15:0] ra, rb, es;
        logic        rci, rsub, ec, eo;
        int          cnt;

        vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[3]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vt[11] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1};

        // Reset with a beat offered: reset must win.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h1111; b = 16'h2222; ci = 1'b0; op_sub = 1'b0;
        cur_s = 16'h3333; cur_c = 1'b0; cur_o = 1'b0;
        sw_valid = 1'b0;
        a4 = '1; b4 = '0; a32 = '1; b32 = '0; a64 = '1; b64 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(out_valid == 1'b0 && sum == 16'h0 && cout == 1'b0 && ovf == 1'b0, "reset_state",
            $sformatf("got out_valid=%b sum=%h cout=%b ovf=%b, want 0 0000 0 0",
                      out_valid, sum, cout, ovf));
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b1, "ready_after_reset", $sformatf("in_ready=%b, want 1", in_ready));
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk(cnt == 0, "reset_dominates", $sformatf("%0d result beats, want 0", cnt));

        // Directed vectors, streamed back to back.
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++)
            send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, vt[i].s, vt[i].c, vt[i].o);
        idle(4);

        // Random streaming.
        for (int i = 0; i < 100; i++) begin
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 65535));
            rci  = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            model(ra, rb, rci, rsub, es, ec, eo);
            send(ra, rb, rci, rsub, es, ec, eo);
        end
        idle(4);
        chk_lat = 1'b0;

        // Backpressure: three beats offered with out_ready low.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            case (i)
                0: begin a = 16'h1111; b = 16'h2222; ci = 1'b0; op_sub = 1'b0;
                         cur_s = 16'h3333; cur_c = 1'b0; cur_o = 1'b0; end
                1: begin a = 16'h9000; b = 16'h1000; ci = 1'b0; op_sub = 1'b1;
                         cur_s = 16'h8000; cur_c = 1'b1; cur_o = 1'b0; end
                default: begin a = 16'hF000; b = 16'h1000; ci = 1'b1; op_sub = 1'b0;
                         cur_s = 16'h0001; cur_c = 1'b1; cur_o = 1'b0; end
            endcase
            @(negedge clk);
            chk(in_ready == (i < 2), "bp_ready",
                $sformatf("beat %0d in_ready=%b, want %b", i, in_ready, (i < 2)));
        end
        repeat (3) begin
            @(negedge clk);
            chk(out_valid == 1'b1 && sum == 16'h3333 && in_ready == 1'b0, "bp_hold",
                $sformatf("got out_valid=%b sum=%h in_ready=%b, want 1 3333 0",
                          out_valid, sum, in_ready));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk(cnt == 2, "bp_release", $sformatf("%0d consecutive results, want 2", cnt));
        @(negedge clk);
        chk(out_valid == 1'b0, "bp_drained", $sformatf("out_valid=%b, want 0", out_valid));

        // Reset mid-stream with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
        send(16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b0 && out_valid == 1'b1 && sum == 16'h0303, "full_before_reset",
            $sformatf("got in_ready=%b out_valid=%b sum=%h, want 0 1 0303",
                      in_ready, out_valid, sum));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk(out_valid == 1'b0 && sum == 16'h0 && cout == 1'b0 && ovf == 1'b0 && in_ready == 1'b1,
            "mid_reset", $sformatf("got out_valid=%b sum=%h cout=%b ovf=%b in_ready=%b, want 0 0000 0 0 1",
                                   out_valid, sum, cout, ovf, in_ready));
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk(cnt == 0, "no_stale_after_reset", $sformatf("%0d result beats, want 0", cnt));

        // Width sweep: all-ones + 0 + 1 wraps to zero with carry out.
        @(posedge clk); #1;
        sw_valid = 1'b1;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(ov4 && s4 == 4'h0 && co4 && !of4 && rdy4, "sweep_w4",
            $sformatf("got valid=%b sum=%h cout=%b ovf=%b ready=%b, want 1 0 1 0 1", ov4, s4, co4, of4, rdy4));
        chk(ov32 && s32 == 32'h0 && co32 && !of32 && rdy32, "sweep_w32",
            $sformatf("got valid=%b sum=%h cout=%b ovf=%b ready=%b, want 1 0 1 0 1", ov32, s32, co32, of32, rdy32));
        chk(ov64 && s64 == 64'h0 && co64 && !of64 && rdy64, "sweep_w64",
            $sformatf("got valid=%b sum=%h cout=%b ovf=%b ready=%b, want 1 0 1 0 1", ov64, s64, co64, of64, rdy64));

        cnt = 0;
        while (q.size() != 0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk(q.size() == 0, "drain", $sformatf("%0d results outstanding, want 0", q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
